// File: rtl/trivium_pkg.sv
// Shared types for the Trivium keystream generator and its consumers.
package trivium_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  // Registered output stage of the keystream XOR block.
  typedef struct packed {
    logic  valid;
    byte_t data;
  } out_stage_t;

endpackage

// File: rtl/trivium_ks_fifo.sv
// Keystream prefetch FIFO: strict in-order buffer with occupancy count and synchronous flush.
module trivium_ks_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  // Guard again here so the FIFO stays consistent even if a caller misbehaves.
  assign do_push = push && (count_q != FULL_COUNT) && !clear;
  assign do_pop  = pop && (count_q != '0) && !clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/trivium_keystream_xor.sv
// Consumer side of the Trivium keystream: prefetches keystream bytes and XORs them onto a
// byte stream through a registered valid/ready output.
module trivium_keystream_xor
  import trivium_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] keystream_byte,
  input  logic              keystream_valid,
  output logic              keystream_read,
  input  logic              clear,
  input  logic [BYTE_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [BYTE_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [CNT_W-1:0]  byte_count
);

  localparam int unsigned FC_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FC_W-1:0] FULL_COUNT = FC_W'(FIFO_DEPTH);

  logic [FC_W-1:0]  fifo_count;
  byte_t            ks_head;
  out_stage_t       out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xfer, beat;

  trivium_ks_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (keystream_read),
    .pop   (xfer),
    .wdata (keystream_byte),
    .rdata (ks_head),
    .count (fifo_count)
  );

  // A full FIFO never pushes, even when a pop frees a slot on the same edge.
  // rst_n gating keeps the strobe low while the block is held in reset.
  assign keystream_read = rst_n && keystream_valid && (fifo_count != FULL_COUNT) && !clear;

  assign din_ready = (fifo_count != '0) && (!out_q.valid || dout_ready) && !clear;
  assign xfer      = din_valid && din_ready;
  assign beat      = out_q.valid && dout_ready && !clear;

  always_comb begin
    out_d = out_q;
    if (clear) begin
      out_d.valid = 1'b0;
    end else if (xfer) begin
      out_d.valid = 1'b1;
      out_d.data  = din ^ ks_head;
    end else if (beat) begin
      out_d.valid = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear)     cnt_d = '0;
    else if (beat) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout       = out_q.data;
  assign dout_valid = out_q.valid;
  assign byte_count = cnt_q;

endmodule
